// File: rtl/seq_div.sv
// Sequential restoring divider: (M_bits+N_bits)-bit dividend / N_bits-bit divisor, one quotient bit per clock.
// Busy for M_bits cycles after Start; SEQ_DIV_ERR_EN adds an Err port and a one-cycle overflow short-cut.
module seq_div #(
  parameter int M_bits = 12,
  parameter int N_bits = 8
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     Start,
  input  logic [M_bits+N_bits-1:0] Dvd,
  input  logic [N_bits-1:0]        Dvr,
  output logic [M_bits-1:0]        Quot,
  output logic [N_bits-1:0]        Rem,
  output logic                     Busy,
  output logic                     Done
`ifdef SEQ_DIV_ERR_EN
  , output logic                   Err
`endif
);

  localparam int CW = $clog2(M_bits + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N_bits:0]     p_q, p_d;
  logic [M_bits-1:0]   q_q, q_d;
  logic [N_bits-1:0]   dvr_q, dvr_d;
  logic [M_bits-1:0]   quot_q, quot_d;
  logic [N_bits-1:0]   rem_q, rem_d;
  logic                done_q, done_d;
`ifdef SEQ_DIV_ERR_EN
  logic                err_q, err_d;
`endif

  logic [N_bits:0]     shifted;
  logic [N_bits+1:0]   trial;

  // One extra bit on the trial subtraction so its msb is the borrow.
  assign shifted = {p_q[N_bits-1:0], q_q[M_bits-1]};
  assign trial   = {1'b0, shifted} - {2'b00, dvr_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    q_d     = q_q;
    dvr_d   = dvr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
`ifdef SEQ_DIV_ERR_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (Start) begin
          dvr_d   = Dvr;
          p_d     = {1'b0, Dvd[M_bits+N_bits-1:M_bits]};
          q_d     = Dvd[M_bits-1:0];
          cnt_d   = CW'(M_bits);
          state_d = RUN;
`ifdef SEQ_DIV_ERR_EN
          // hi >= Dvr also covers Dvr == 0: the quotient cannot fit in M_bits.
          if (Dvd[M_bits+N_bits-1:M_bits] >= Dvr) begin
            state_d = IDLE;
            cnt_d   = '0;
            quot_d  = '1;
            rem_d   = '0;
            err_d   = 1'b1;
            done_d  = 1'b1;
          end
`endif
        end
      end
      RUN: begin
        if (!trial[N_bits+1]) begin
          p_d = trial[N_bits:0];
          q_d = {q_q[M_bits-2:0], 1'b1};
        end else begin
          p_d = shifted;
          q_d = {q_q[M_bits-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          quot_d  = q_d;
          rem_d   = p_d[N_bits-1:0];
          done_d  = 1'b1;
`ifdef SEQ_DIV_ERR_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      dvr_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
`ifdef SEQ_DIV_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      q_q     <= q_d;
      dvr_q   <= dvr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
`ifdef SEQ_DIV_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  assign Quot = quot_q;
  assign Rem  = rem_q;
  assign Busy = (state_q == RUN);
  assign Done = done_q;
`ifdef SEQ_DIV_ERR_EN
  assign Err  = err_q;
`endif

endmodule

// File: tb/tb_seq_div.sv
// Directed bench for seq_div: vector table, back-to-back, mid-run Start, mid-run reset, multiply cross-check.
module tb_seq_div;

  localparam int M = 12;
  localparam int N = 8;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b0;
  logic         Start = 1'b0;
  logic [M+N-1:0] Dvd = '0;
  logic [N-1:0] Dvr = '0;
  logic [M-1:0] Quot;
  logic [N-1:0] Rem;
  logic         Busy;
  logic         Done;
`ifdef SEQ_DIV_ERR_EN
  logic         Err;
`endif

  seq_div #(.M_bits(M), .N_bits(N)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Dvd(Dvd), .Dvr(Dvr),
    .Quot(Quot), .Rem(Rem), .Busy(Busy), .Done(Done)
`ifdef SEQ_DIV_ERR_EN
    , .Err(Err)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int dvd;
    int dvr;
    int exp_q;
    int exp_r;
  } vec_t;

  vec_t vecs[8];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the first negedge with Busy low.
  task automatic wait_done(input int pulse_at, output int cyc);
    cyc = 0;
    while (Busy && cyc < 50) begin
      cyc++;
      if (pulse_at > 0) begin
        Start = (cyc == pulse_at);
        if (cyc == pulse_at) begin
          Dvd = 20'd1000;
          Dvr = 8'd7;
        end
      end
      @(negedge Clk);
    end
  endtask

  task automatic do_op(input int dvd, input int dvr, output int cyc);
    logic [31:0] d32;
    d32 = dvd;
    @(negedge Clk);
    Dvd   = d32[M+N-1:0];
    Dvr   = dvr[N-1:0];
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    wait_done(0, cyc);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{1000,    7,   142, 6};
    vecs[1] = '{1044225, 255, 4095, 0};
    vecs[2] = '{0,       1,   0,   0};
    vecs[3] = '{500,     3,   166, 2};
    vecs[4] = '{255,     16,  15,  15};
    vecs[5] = '{1044479, 255, 4095, 254};
    vecs[6] = '{4095,    1,   4095, 0};
    vecs[7] = '{12345,   100, 123, 45};

    repeat (3) @(negedge Clk);
    check("reset_quot", int'(Quot), 0);
    check("reset_rem",  int'(Rem),  0);
    check("reset_busy", int'(Busy), 0);
    check("reset_done", int'(Done), 0);
    Rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].dvd, vecs[i].dvr, cyc);
      check($sformatf("v%0d_busy_cycles", i), cyc, M);
      check($sformatf("v%0d_done", i), int'(Done), 1);
      check($sformatf("v%0d_quot", i), int'(Quot), vecs[i].exp_q);
      check($sformatf("v%0d_rem", i),  int'(Rem),  vecs[i].exp_r);
      @(negedge Clk);
      check($sformatf("v%0d_done_pulse", i), int'(Done), 0);
      check($sformatf("v%0d_hold_quot", i), int'(Quot), vecs[i].exp_q);
    end

    // Start held across Done: second operation starts on the Done edge.
    @(negedge Clk);
    Dvd = 20'd500; Dvr = 8'd3; Start = 1'b1;
    @(negedge Clk);
    Dvd = 20'd255; Dvr = 8'd16;
    wait_done(0, cyc);
    check("b2b1_busy_cycles", cyc, M);
    check("b2b1_done", int'(Done), 1);
    check("b2b1_quot", int'(Quot), 166);
    check("b2b1_rem",  int'(Rem),  2);
    @(negedge Clk);
    Start = 1'b0;
    check("b2b2_no_gap_busy", int'(Busy), 1);
    check("b2b2_done_low", int'(Done), 0);
    wait_done(5, cyc);
    check("b2b2_busy_cycles", cyc, M);
    check("b2b2_done", int'(Done), 1);
    check("b2b2_quot", int'(Quot), 15);
    check("b2b2_rem",  int'(Rem),  15);
    @(negedge Clk);
    check("midstart_ignored_busy", int'(Busy), 0);

    // Reset during RUN aborts the operation with no Done.
    @(negedge Clk);
    Dvd = 20'd1000; Dvr = 8'd7; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (4) @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    check("abort_busy", int'(Busy), 0);
    check("abort_quot", int'(Quot), 0);
    check("abort_rem",  int'(Rem),  0);
    check("abort_done", int'(Done), 0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (14) begin
      @(negedge Clk);
      check("abort_no_done", int'(Done), 0);
    end
    do_op(1000, 7, cyc);
    check("after_abort_quot", int'(Quot), 142);
    check("after_abort_rem",  int'(Rem),  6);

`ifdef SEQ_DIV_ERR_EN
    do_op(1000, 0, cyc);
    check("err_dvr0_busy_cycles", cyc, 0);
    check("err_dvr0_done", int'(Done), 1);
    check("err_dvr0_err",  int'(Err), 1);
    check("err_dvr0_quot", int'(Quot), 4095);
    check("err_dvr0_rem",  int'(Rem), 0);
    do_op(20'hFFFFF, 1, cyc);
    check("err_ovf_busy_cycles", cyc, 0);
    check("err_ovf_err",  int'(Err), 1);
    check("err_ovf_quot", int'(Quot), 4095);
    do_op(1000, 7, cyc);
    check("err_clear_err",  int'(Err), 0);
    check("err_clear_quot", int'(Quot), 142);
`endif

    // Product of a shift-add multiply divided by its multiplier gives back the multiplicand.
    for (int mpd = 0; mpd < 127; mpd += 9) begin
      for (int mpr = 1; mpr < 127; mpr += 11) begin
        do_op(mpd * mpr, mpr, cyc);
        check($sformatf("xmul_%0dx%0d_quot", mpd, mpr), int'(Quot), mpd);
        check($sformatf("xmul_%0dx%0d_rem", mpd, mpr),  int'(Rem),  0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
